// File: rtl/bsg_mul_riscv_pkg.sv
// Shared types for the RISC-V M-extension multiply control stage:
// op encoding (funct3 low bits), FSM states and operand signedness mapping.
package bsg_mul_riscv_pkg;

    typedef enum logic [1:0] {
        eMUL    = 2'd0,
        eMULH   = 2'd1,
        eMULHSU = 2'd2,
        eMULHU  = 2'd3
    } bsg_mul_op_e;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eISSUE = 2'd1,
        eWAIT  = 2'd2,
        eOUT   = 2'd3
    } bsg_mul_state_e;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } bsg_mul_sign_s;

    // MUL takes s/s: its low half does not depend on signedness anyway.
    function automatic bsg_mul_sign_s bsg_mul_op_sign(input bsg_mul_op_e op);
        bsg_mul_sign_s s;
        s.a_signed = (op != eMULHU);
        s.b_signed = (op == eMUL) || (op == eMULH);
        return s;
    endfunction

endpackage

// File: rtl/bsg_mul_riscv_ctrl_cache.sv
// One-entry product-reuse tag store (operands + signedness of the last product).
// Only instantiated when BSG_MUL_RISCV_CTRL_REUSE_EN is defined.
module bsg_mul_riscv_ctrl_cache
    import bsg_mul_riscv_pkg::*;
#(
    parameter int unsigned width_p = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_capture,
    input  logic [width_p-1:0] i_cap_rs1,
    input  logic [width_p-1:0] i_cap_rs2,
    input  bsg_mul_sign_s      i_cap_sign,
    input  logic [width_p-1:0] i_rs1,
    input  logic [width_p-1:0] i_rs2,
    input  bsg_mul_sign_s      i_sign,
    input  logic               i_is_mul,
    output logic               o_hit_c
);

    logic               r_valid;
    logic [width_p-1:0] r_rs1;
    logic [width_p-1:0] r_rs2;
    bsg_mul_sign_s      r_sign;

    // Entry is refreshed on every product capture; only reset invalidates it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_sign  <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_rs1   <= i_cap_rs1;
            r_rs2   <= i_cap_rs2;
            r_sign  <= i_cap_sign;
        end
    end

    // MUL only needs the low half, which is identical for every signedness.
    assign o_hit_c = r_valid && (i_rs1 == r_rs1) && (i_rs2 == r_rs2)
                     && (i_is_mul || (i_sign == r_sign));

endmodule

// File: rtl/bsg_mul_riscv_ctrl.sv
// Control stage around an iterative multiplier for MUL/MULH/MULHSU/MULHU.
// Optional product reuse enabled by defining BSG_MUL_RISCV_CTRL_REUSE_EN.
module bsg_mul_riscv_ctrl
    import bsg_mul_riscv_pkg::*;
#(
    parameter int unsigned width_p     = 32,
    parameter int unsigned tag_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  bsg_mul_op_e            op_i,
    input  logic [width_p-1:0]     rs1_i,
    input  logic [width_p-1:0]     rs2_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i,
    output logic                   mul_v_o,
    input  logic                   mul_ready_i,
    output logic [width_p-1:0]     mul_opA_o,
    output logic [width_p-1:0]     mul_opB_o,
    output logic                   mul_opA_is_signed_o,
    output logic                   mul_opB_is_signed_o,
    input  logic                   mul_v_i,
    input  logic [2*width_p-1:0]   mul_result_i,
    output logic                   mul_yumi_o
);

    bsg_mul_state_e         r_state;
    bsg_mul_state_e         w_state_next;
    logic [width_p-1:0]     r_rs1;
    logic [width_p-1:0]     r_rs2;
    bsg_mul_op_e            r_op;
    bsg_mul_sign_s          r_sign;
    logic [tag_width_p-1:0] r_tag;
    logic [2*width_p-1:0]   r_product;

    logic                   w_accept;
    logic                   w_capture;
    logic                   w_hit;
    bsg_mul_sign_s          w_sign;

    assign w_sign    = bsg_mul_op_sign(op_i);
    assign w_accept  = (r_state == eIDLE) && v_i;
    assign w_capture = (r_state == eWAIT) && mul_v_i;

`ifdef BSG_MUL_RISCV_CTRL_REUSE_EN
    logic w_hit_c;

    bsg_mul_riscv_ctrl_cache #(
        .width_p (width_p)
    ) u_cache (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_capture  (w_capture),
        .i_cap_rs1  (r_rs1),
        .i_cap_rs2  (r_rs2),
        .i_cap_sign (r_sign),
        .i_rs1      (rs1_i),
        .i_rs2      (rs2_i),
        .i_sign     (w_sign),
        .i_is_mul   (op_i == eMUL),
        .o_hit_c    (w_hit_c)
    );

    assign w_hit = w_hit_c;
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        v_o          = 1'b0;
        mul_v_o      = 1'b0;
        mul_yumi_o   = 1'b0;
        case (r_state)
            eIDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    w_state_next = w_hit ? eOUT : eISSUE;
                end
            end
            eISSUE: begin
                mul_v_o = 1'b1;
                if (mul_ready_i) begin
                    w_state_next = eWAIT;
                end
            end
            eWAIT: begin
                if (mul_v_i) begin
                    mul_yumi_o   = 1'b1;
                    w_state_next = eOUT;
                end
            end
            eOUT: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    w_state_next = eIDLE;
                end
            end
            default: w_state_next = eIDLE;
        endcase
    end

    // Request fields latched at accept; product only written by the multiplier handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_op      <= eMUL;
            r_sign    <= '0;
            r_tag     <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_rs1  <= rs1_i;
                r_rs2  <= rs2_i;
                r_op   <= op_i;
                r_sign <= w_sign;
                r_tag  <= tag_i;
            end
            if (w_capture) begin
                r_product <= mul_result_i;
            end
        end
    end

    assign mul_opA_o           = r_rs1;
    assign mul_opB_o           = r_rs2;
    assign mul_opA_is_signed_o = r_sign.a_signed;
    assign mul_opB_is_signed_o = r_sign.b_signed;

    assign result_o = (r_op == eMUL) ? r_product[width_p-1:0]
                                     : r_product[2*width_p-1:width_p];
    assign tag_o    = r_tag;

endmodule

// File: tb/tb_bsg_mul_riscv_ctrl.sv
// Directed bench for bsg_mul_riscv_ctrl; the bench plays the multiplier and the consumer.
// Adapts its hit expectations when BSG_MUL_RISCV_CTRL_REUSE_EN is defined.
module tb_bsg_mul_riscv_ctrl;
    import bsg_mul_riscv_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          ready_o;
    bsg_mul_op_e   op_i = eMUL;
    logic [W-1:0]  rs1_i = '0;
    logic [W-1:0]  rs2_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          v_o;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;
    logic          yumi_i = 1'b0;
    logic          mul_v_o;
    logic          mul_ready_i = 1'b0;
    logic [W-1:0]  mul_opA_o;
    logic [W-1:0]  mul_opB_o;
    logic          mul_opA_is_signed_o;
    logic          mul_opB_is_signed_o;
    logic          mul_v_i = 1'b0;
    logic [2*W-1:0] mul_result_i = '0;
    logic          mul_yumi_o;

    bsg_mul_riscv_ctrl #(.width_p(W), .tag_width_p(TW)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .v_i                 (v_i),
        .ready_o             (ready_o),
        .op_i                (op_i),
        .rs1_i               (rs1_i),
        .rs2_i               (rs2_i),
        .tag_i               (tag_i),
        .v_o                 (v_o),
        .result_o            (result_o),
        .tag_o               (tag_o),
        .yumi_i              (yumi_i),
        .mul_v_o             (mul_v_o),
        .mul_ready_i         (mul_ready_i),
        .mul_opA_o           (mul_opA_o),
        .mul_opB_o           (mul_opB_o),
        .mul_opA_is_signed_o (mul_opA_is_signed_o),
        .mul_opB_is_signed_o (mul_opB_is_signed_o),
        .mul_v_i             (mul_v_i),
        .mul_result_i        (mul_result_i),
        .mul_yumi_o          (mul_yumi_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit reuse_en = 1'b0;

    // Reference model of the reuse entry
    bit           c_valid = 1'b0;
    logic [W-1:0] c_a = '0;
    logic [W-1:0] c_b = '0;
    logic [1:0]   c_sign = '0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [1:0] sign_of(input logic [1:0] op);
        case (op)
            2'd0:    return 2'b11;
            2'd1:    return 2'b11;
            2'd2:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Multiplier stand-in: multiplies whatever operands/signedness the DUT presents.
    function automatic logic [63:0] stub_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic as, input logic bs);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = as ? {{32{a[31]}}, a} : {32'b0, a};
        eb = bs ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Architectural result of the RISC-V instruction
    function automatic logic [W-1:0] golden(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] p;
        case (op)
            2'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            2'd1: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                sp = sa * sb; p = sp; return p[63:32];
            end
            2'd2: begin
                sa = longint'($signed(a)); sb = longint'({32'b0, b});
                sp = sa * sb; p = sp; return p[63:32];
            end
            default: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One full transaction; multiplier stalls, latency and consumer stalls are parameters.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input logic [W-1:0] exp_res,
                          input int rdy_stall, input int lat, input int yumi_stall);
        bit          hit;
        logic [1:0]  s;
        logic [63:0] prod;
        s   = sign_of(op);
        hit = reuse_en && c_valid && (a == c_a) && (b == c_b) && ((op == 2'd0) || (s == c_sign));
        @(negedge clk_i);
        chk("ready_idle", 64'(ready_o), 64'(1));
        v_i = 1'b1; op_i = bsg_mul_op_e'(op); rs1_i = a; rs2_i = b; tag_i = tag;
        @(negedge clk_i);
        v_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; tag_i = TW'($urandom);
        if (hit) begin
            chk("hit_v_o", 64'(v_o), 64'(1));
            chk("hit_no_mul_v", 64'(mul_v_o), 64'(0));
        end else begin
            mul_ready_i = 1'b0;
            yumi_i      = 1'b1;
            for (int i = 0; i < rdy_stall; i++) begin
                chk("stall_mul_v", 64'(mul_v_o), 64'(1));
                chk("stall_opA", 64'(mul_opA_o), 64'(a));
                chk("stall_opB", 64'(mul_opB_o), 64'(b));
                chk("stall_ready_low", 64'(ready_o), 64'(0));
                @(negedge clk_i);
            end
            chk("issue_mul_v", 64'(mul_v_o), 64'(1));
            chk("issue_opA", 64'(mul_opA_o), 64'(a));
            chk("issue_opB", 64'(mul_opB_o), 64'(b));
            chk("issue_sign", 64'({mul_opA_is_signed_o, mul_opB_is_signed_o}), 64'(s));
            prod = stub_product(mul_opA_o, mul_opB_o, mul_opA_is_signed_o, mul_opB_is_signed_o);
            mul_ready_i = 1'b1;
            @(negedge clk_i);
            mul_ready_i = 1'b0;
            chk("wait_mul_v_low", 64'(mul_v_o), 64'(0));
            for (int i = 0; i < lat; i++) begin
                chk("wait_no_yumi", 64'(mul_yumi_o), 64'(0));
                chk("wait_no_v", 64'(v_o), 64'(0));
                @(negedge clk_i);
            end
            yumi_i = 1'b0; mul_v_i = 1'b1; mul_result_i = prod;
            #1;
            chk("mul_yumi", 64'(mul_yumi_o), 64'(1));
            @(negedge clk_i);
            mul_v_i = 1'b0; mul_result_i = 64'hDEAD_BEEF_0BAD_F00D;
            c_valid = 1'b1; c_a = a; c_b = b; c_sign = s;
        end
        for (int i = 0; i < yumi_stall; i++) begin
            chk("out_hold_v", 64'(v_o), 64'(1));
            chk("out_hold_result", 64'(result_o), 64'(exp_res));
            chk("out_hold_tag", 64'(tag_o), 64'(tag));
            chk("out_hold_ready", 64'(ready_o), 64'(0));
            mul_v_i = 1'b1; mul_result_i = 64'h1234_5678_9ABC_DEF0;
            #1;
            chk("out_stray_yumi", 64'(mul_yumi_o), 64'(0));
            @(negedge clk_i);
            mul_v_i = 1'b0;
        end
        chk("out_v", 64'(v_o), 64'(1));
        chk("out_result", 64'(result_o), 64'(exp_res));
        chk("out_tag", 64'(tag_o), 64'(tag));
        chk("out_no_mul_v", 64'(mul_v_o), 64'(0));
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
        chk("after_yumi_v", 64'(v_o), 64'(0));
    endtask

    initial begin
        logic [1:0]    rop;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [TW-1:0] rt;
`ifdef BSG_MUL_RISCV_CTRL_REUSE_EN
        reuse_en = 1'b1;
`endif
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        chk("rst_ready", 64'(ready_o), 64'(1));
        chk("rst_v", 64'(v_o), 64'(0));
        chk("rst_mul_v", 64'(mul_v_o), 64'(0));
        chk("rst_mul_yumi", 64'(mul_yumi_o), 64'(0));
        chk("rst_result", 64'(result_o), 64'(0));
        chk("rst_tag", 64'(tag_o), 64'(0));
        chk("rst_opA", 64'(mul_opA_o), 64'(0));
        chk("rst_opB", 64'(mul_opB_o), 64'(0));

        // MULHU with multiplier and consumer backpressure
        run_op(2'd3, 32'hFFFF_FFFF, 32'h2, 8'h11, 32'h0000_0001, 5, 2, 4);
        run_op(2'd1, 32'hFFFF_FFFF, 32'h2, 8'h22, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'h2, 8'h33, 32'hFFFF_FFFF, 1, 1, 1);
        // MULH then MUL on the same operands
        run_op(2'd1, 32'h7, 32'h6, 8'h44, 32'h0, 0, 1, 0);
        run_op(2'd0, 32'h7, 32'h6, 8'h45, 32'd42, 0, 1, 0);

        // Reset while waiting on the product
        @(negedge clk_i);
        v_i = 1'b1; op_i = eMULHU; rs1_i = 32'h3; rs2_i = 32'h5; tag_i = 8'h5A;
        @(negedge clk_i);
        v_i = 1'b0;
        chk("rr_mul_v", 64'(mul_v_o), 64'(1));
        mul_ready_i = 1'b1;
        @(negedge clk_i);
        mul_ready_i = 1'b0;
        chk("rr_in_wait", 64'(mul_v_o), 64'(0));
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        c_valid = 1'b0;
        chk("rr_ready", 64'(ready_o), 64'(1));
        chk("rr_v", 64'(v_o), 64'(0));
        mul_v_i = 1'b1; mul_result_i = 64'h0000_0000_0000_000F;
        #1;
        chk("rr_no_yumi", 64'(mul_yumi_o), 64'(0));
        @(negedge clk_i);
        mul_v_i = 1'b0;
        chk("rr_v_after", 64'(v_o), 64'(0));
        chk("rr_ready_after", 64'(ready_o), 64'(1));
        chk("rr_result", 64'(result_o), 64'(0));
        run_op(2'd1, 32'h7, 32'h6, 8'h66, 32'h0, 0, 0, 0);
        run_op(2'd0, 32'h7, 32'h6, 8'h67, 32'd42, 0, 0, 0);

        // Mixed ops with random stalls
        for (int n = 0; n < 100; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            rt  = TW'($urandom);
            run_op(rop, ra, rb, rt, golden(rop, ra, rb),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
